// File: rtl/mem_requester.sv
// rtl/mem_requester.sv - single-outstanding load/store initiator for the 16-bit data memory
// Serialises pipeline requests onto the memory pins; every mem_* output comes from a register.
module mem_requester #(
  parameter int LAT         = 1,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  input  logic        dump_req,
  output logic        dump_done,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        mem_createdump,
  output logic [15:0] acc_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP,
    S_DUMP
  } state_e;

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          wr_q;
  logic          rsp_valid_q;
  logic          rsp_err_q;
  logic [15:0]   rsp_rdata_q;
  logic          dump_done_q;
  logic          mem_en_q;
  logic          mem_wr_q;
  logic [15:0]   mem_addr_q;
  logic [15:0]   mem_wdata_q;
  logic          createdump_q;
  logic [15:0]   acc_q;

  // A pending dump request blocks new loads/stores from being accepted.
  assign req_ready = (state_q == S_IDLE) && !dump_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= 16'h0000;
      dump_done_q  <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= 16'h0000;
      mem_wdata_q  <= 16'h0000;
      createdump_q <= 1'b0;
      acc_q        <= 16'h0000;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (dump_req) begin
            state_q      <= S_DUMP;
            createdump_q <= 1'b1;
            dump_done_q  <= 1'b1;
          end else if (req_valid) begin
            wr_q <= req_wr;
            if (ALIGN_CHECK && req_addr[0]) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= 16'h0000;
            end else begin
              state_q     <= S_ACCESS;
              mem_en_q    <= 1'b1;
              // A store writes only on its last enabled cycle: one write edge.
              mem_wr_q    <= req_wr && (LAT == 1);
              mem_addr_q  <= req_addr;
              mem_wdata_q <= req_wdata;
              cnt_q       <= CW'(LAT - 1);
            end
          end
        end
        S_ACCESS: begin
          if (cnt_q == '0) begin
            state_q     <= S_RESP;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= wr_q ? 16'h0000 : mem_rdata;
            acc_q       <= acc_q + 16'd1;
          end else begin
            cnt_q    <= cnt_q - CW'(1);
            mem_wr_q <= wr_q && (cnt_q == CW'(1));
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 16'h0000;
          end
        end
        S_DUMP: begin
          state_q      <= S_IDLE;
          createdump_q <= 1'b0;
          dump_done_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid      = rsp_valid_q;
  assign rsp_err        = rsp_err_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign dump_done      = dump_done_q;
  assign mem_en         = mem_en_q;
  assign mem_wr         = mem_wr_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_createdump = createdump_q;
  assign acc_count      = acc_q;

endmodule

// File: tb/tb_mem_requester.sv
// tb/tb_mem_requester.sv - directed bench: three requesters (LAT 1/3/2) each on a byte memory model
module tb_mem_requester;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [3];
  logic        req_valid [3];
  logic        req_wr    [3];
  logic [15:0] req_addr  [3];
  logic [15:0] req_wdata [3];
  logic        rsp_ready [3];
  logic        dump_req  [3];
  logic        req_ready [3];
  logic        rsp_valid [3];
  logic [15:0] rsp_rdata [3];
  logic        rsp_err   [3];
  logic        dump_done [3];
  logic        mem_en    [3];
  logic        mem_wr    [3];
  logic [15:0] mem_addr  [3];
  logic [15:0] mem_wdata [3];
  logic [15:0] mem_rdata [3];
  logic        mem_cd    [3];
  logic [15:0] acc_count [3];

  logic [7:0] mem [3][65536];
  int en_cnt [3];
  int wr_cnt [3];
  int dump_cnt [3];
  int overlap_cnt = 0;
  int tests = 0;
  int fails = 0;

  mem_requester #(.LAT(1), .ALIGN_CHECK(1'b1)) u0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_wr(req_wr[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .dump_req(dump_req[0]), .dump_done(dump_done[0]),
    .mem_en(mem_en[0]), .mem_wr(mem_wr[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .mem_createdump(mem_cd[0]), .acc_count(acc_count[0]));

  mem_requester #(.LAT(3), .ALIGN_CHECK(1'b1)) u1 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_wr(req_wr[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .dump_req(dump_req[1]), .dump_done(dump_done[1]),
    .mem_en(mem_en[1]), .mem_wr(mem_wr[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .mem_createdump(mem_cd[1]), .acc_count(acc_count[1]));

  mem_requester #(.LAT(2), .ALIGN_CHECK(1'b0)) u2 (
    .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_wr(req_wr[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]),
    .rsp_err(rsp_err[2]), .dump_req(dump_req[2]), .dump_done(dump_done[2]),
    .mem_en(mem_en[2]), .mem_wr(mem_wr[2]), .mem_addr(mem_addr[2]), .mem_wdata(mem_wdata[2]),
    .mem_rdata(mem_rdata[2]), .mem_createdump(mem_cd[2]), .acc_count(acc_count[2]));

  // Big-endian memory: [15:8] at addr, [7:0] at addr+1 (wrapping); data only while reading.
  for (genvar g = 0; g < 3; g++) begin : g_mem
    assign mem_rdata[g] = (mem_en[g] && !mem_wr[g]) ?
                          {mem[g][mem_addr[g]], mem[g][mem_addr[g] + 16'd1]} : 16'hxxxx;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (mem_en[i]) en_cnt[i]++;
      if (mem_en[i] && mem_wr[i]) begin
        wr_cnt[i]++;
        mem[i][mem_addr[i]]         <= mem_wdata[i][15:8];
        mem[i][mem_addr[i] + 16'd1] <= mem_wdata[i][7:0];
      end
      if (mem_cd[i]) dump_cnt[i]++;
      if (mem_en[i] && mem_cd[i]) overlap_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int i, input logic wr, input logic [15:0] addr,
                      input logic [15:0] wdata, output int edges);
    logic acc;
    int n;
    req_wr[i] = wr;
    req_addr[i] = addr;
    req_wdata[i] = wdata;
    req_valid[i] = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = req_ready[i];
      step();
      n++;
    end
    req_valid[i] = 1'b0;
    check("accept", {31'd0, acc}, 32'd1);
    edges = 1;
    while (!rsp_valid[i] && edges < 20) begin
      step();
      edges++;
    end
  endtask

  task automatic recv(input int i, output logic [15:0] data, output logic err);
    data = rsp_rdata[i];
    err = rsp_err[i];
    rsp_ready[i] = 1'b1;
    step();
    rsp_ready[i] = 1'b0;
    check("rsp_clear", {13'd0, rsp_valid[i], rsp_err[i], rsp_rdata[i], req_ready[i]},
          {13'd0, 1'b0, 1'b0, 16'h0000, 1'b1});
  endtask

  initial begin
    int e;
    int en0;
    int wr0;
    int d0;
    logic [15:0] d;
    logic er;

    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      req_valid[i] = 1'b0;
      req_wr[i] = 1'b0;
      req_addr[i] = 16'h0000;
      req_wdata[i] = 16'h0000;
      rsp_ready[i] = 1'b0;
      dump_req[i] = 1'b0;
      en_cnt[i] = 0;
      wr_cnt[i] = 0;
      dump_cnt[i] = 0;
    end
    repeat (3) begin
      step();
      check("rst_mem_en", {29'd0, mem_en[0], mem_en[1], mem_en[2]}, 32'd0);
    end
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    check("reset_outs", {25'd0, req_ready[0], rsp_valid[0], rsp_err[0], dump_done[0],
          mem_en[0], mem_wr[0], mem_cd[0]}, 32'b1000000);
    check("reset_acc", {16'd0, acc_count[0]}, 32'd0);
    check("reset_data", {rsp_rdata[0], mem_addr[0]}, 32'd0);

    // Store then load at LAT=1
    send(0, 1'b1, 16'h0010, 16'hBEEF, e);
    check("t1_st_lat", e, 2);
    recv(0, d, er);
    check("t1_st_rsp", {15'd0, er, d}, 32'd0);
    check("t1_st_acc", {16'd0, acc_count[0]}, 32'd1);
    send(0, 1'b0, 16'h0010, 16'h0000, e);
    check("t1_ld_lat", e, 2);
    recv(0, d, er);
    check("t1_ld_rsp", {15'd0, er, d}, {15'd0, 1'b0, 16'hBEEF});
    check("t1_acc", {16'd0, acc_count[0]}, 32'd2);
    check("t1_wr_cycles", wr_cnt[0], 1);

    // LAT=3: enable held three cycles, write strobe only on the last
    en0 = en_cnt[1];
    wr0 = wr_cnt[1];
    send(1, 1'b1, 16'h0000, 16'h1234, e);
    check("t2_st_lat", e, 4);
    recv(1, d, er);
    check("t2_st_en", en_cnt[1] - en0, 3);
    check("t2_st_wr", wr_cnt[1] - wr0, 1);
    en0 = en_cnt[1];
    wr0 = wr_cnt[1];
    send(1, 1'b0, 16'h0000, 16'h0000, e);
    check("t2_ld_lat", e, 4);
    recv(1, d, er);
    check("t2_ld_data", {16'd0, d}, 32'h1234);
    check("t2_ld_en", en_cnt[1] - en0, 3);
    check("t2_ld_wr", wr_cnt[1] - wr0, 0);
    check("t2_acc", {16'd0, acc_count[1]}, 32'd2);

    // Misaligned requests
    en0 = en_cnt[0];
    send(0, 1'b0, 16'h0011, 16'h0000, e);
    check("t3_lat", e, 1);
    recv(0, d, er);
    check("t3_rsp", {15'd0, er, d}, {15'd0, 1'b1, 16'h0000});
    send(0, 1'b1, 16'hFFFF, 16'h1111, e);
    recv(0, d, er);
    check("t3_ffff_err", {31'd0, er}, 32'd1);
    check("t3_no_en", en_cnt[0] - en0, 0);
    check("t3_acc", {16'd0, acc_count[0]}, 32'd2);
    send(0, 1'b1, 16'hFFFE, 16'hA1B2, e);
    recv(0, d, er);
    check("t3_fffe_err", {31'd0, er}, 32'd0);
    send(0, 1'b0, 16'hFFFE, 16'h0000, e);
    recv(0, d, er);
    check("t3_fffe_data", {16'd0, d}, 32'hA1B2);
    check("t3_acc2", {16'd0, acc_count[0]}, 32'd4);

    // Response backpressure
    send(0, 1'b0, 16'h0010, 16'h0000, e);
    check("t4_lat", e, 2);
    en0 = en_cnt[0];
    repeat (5) begin
      step();
      check("t4_hold", {14'd0, rsp_valid[0], rsp_rdata[0], req_ready[0]},
            {14'd0, 1'b1, 16'hBEEF, 1'b0});
    end
    check("t4_no_en", en_cnt[0] - en0, 0);
    recv(0, d, er);
    check("t4_data", {16'd0, d}, 32'hBEEF);
    check("t4_acc", {16'd0, acc_count[0]}, 32'd5);

    // Dump beats a simultaneous request; request goes through afterwards
    d0 = dump_cnt[0];
    dump_req[0] = 1'b1;
    req_wr[0] = 1'b1;
    req_addr[0] = 16'h0020;
    req_wdata[0] = 16'h5678;
    req_valid[0] = 1'b1;
    @(negedge clk);
    check("t5_ready_low", {31'd0, req_ready[0]}, 32'd0);
    step();
    check("t5_dump", {29'd0, mem_cd[0], dump_done[0], mem_en[0]}, 32'b110);
    dump_req[0] = 1'b0;
    send(0, 1'b1, 16'h0020, 16'h5678, e);
    check("t5_lat", e, 2);
    recv(0, d, er);
    check("t5_dump_cnt", dump_cnt[0] - d0, 1);
    send(0, 1'b0, 16'h0020, 16'h0000, e);
    recv(0, d, er);
    check("t5_data", {16'd0, d}, 32'h5678);
    check("t5_acc", {16'd0, acc_count[0]}, 32'd7);

    // Reset in the middle of a LAT=2 store
    wr0 = wr_cnt[2];
    req_wr[2] = 1'b1;
    req_addr[2] = 16'h0040;
    req_wdata[2] = 16'hCAFE;
    req_valid[2] = 1'b1;
    @(negedge clk);
    check("t6_ready", {31'd0, req_ready[2]}, 32'd1);
    step();
    req_valid[2] = 1'b0;
    check("t6_access", {30'd0, mem_en[2], mem_wr[2]}, 32'b10);
    rst[2] = 1'b1;
    step();
    rst[2] = 1'b0;
    check("t6_rst_outs", {25'd0, req_ready[2], rsp_valid[2], rsp_err[2], dump_done[2],
          mem_en[2], mem_wr[2], mem_cd[2]}, 32'b1000000);
    check("t6_rst_bus", {mem_addr[2], mem_wdata[2]}, 32'd0);
    check("t6_rst_acc", {16'd0, acc_count[2]}, 32'd0);
    step();
    check("t6_idle", {30'd0, mem_en[2], rsp_valid[2]}, 32'd0);
    check("t6_no_write", wr_cnt[2] - wr0, 0);

    // No alignment check: 0xFFFF passed through, memory wraps the second byte
    send(2, 1'b1, 16'hFFFF, 16'hABCD, e);
    check("t6_ffff_lat", e, 3);
    recv(2, d, er);
    check("t6_ffff_err", {31'd0, er}, 32'd0);
    check("t6_wrap_byte", {24'd0, mem[2][0]}, 32'hCD);
    send(2, 1'b0, 16'hFFFF, 16'h0000, e);
    recv(2, d, er);
    check("t6_ffff_data", {16'd0, d}, 32'hABCD);
    check("t6_acc", {16'd0, acc_count[2]}, 32'd2);

    check("en_cd_overlap", overlap_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
